// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, launches mult/div from E-stage, counts
// latency and raises the D-stage stall for MDU-class instructions.
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  E_MDU_Ctr,
   input  logic [31:0] E_A,
   input  logic [31:0] E_B,
   input  logic        Req,
   input  logic        D_MDU_Use,
   output logic [31:0] E_HI,
   output logic [31:0] E_LO,
   output logic        start,
   output logic        busy,
   output logic        D_Stall_MDU
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   logic [0:0]  state;
   logic [31:0] cnt;
   logic [31:0] temp_hi;
   logic [31:0] temp_lo;
   logic        skip_write;

   logic               is_mult;
   logic               is_div;
   logic               div_zero;
   logic signed [63:0] a_sx;
   logic signed [63:0] b_sx;
   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;
   logic [31:0]        divisor;
   logic [31:0]        res_hi;
   logic [31:0]        res_lo;

   assign is_mult     = (E_MDU_Ctr == OP_MULT) || (E_MDU_Ctr == OP_MULTU);
   assign is_div      = (E_MDU_Ctr == OP_DIV)  || (E_MDU_Ctr == OP_DIVU);
   assign div_zero    = (E_B == 32'd0);
   assign start       = (is_mult || is_div) && !Req && (state == IDLE);
   assign D_Stall_MDU = D_MDU_Use && (start || busy);

   // A zero divisor is replaced by one so the divider never produces X; the
   // result is discarded at completion anyway.
   assign divisor = div_zero ? 32'd1 : E_B;
   assign a_sx    = {{32{E_A[31]}}, E_A};
   assign b_sx    = {{32{E_B[31]}}, E_B};
   assign prod_s  = a_sx * b_sx;
   assign prod_u  = {32'd0, E_A} * {32'd0, E_B};

   always_comb begin
      res_hi = 32'd0;
      res_lo = 32'd0;
      case (E_MDU_Ctr)
         OP_MULT: begin
            res_hi = prod_s[63:32];
            res_lo = prod_s[31:0];
         end
         OP_MULTU: begin
            res_hi = prod_u[63:32];
            res_lo = prod_u[31:0];
         end
         OP_DIV: begin
            if (E_A == 32'h8000_0000 && E_B == 32'hFFFF_FFFF) begin
               res_hi = 32'd0;
               res_lo = 32'h8000_0000;
            end else begin
               res_hi = $signed(E_A) % $signed(divisor);
               res_lo = $signed(E_A) / $signed(divisor);
            end
         end
         OP_DIVU: begin
            res_hi = E_A % divisor;
            res_lo = E_A / divisor;
         end
         default: begin
            res_hi = 32'd0;
            res_lo = 32'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         busy       <= 1'b0;
         cnt        <= 32'd0;
         temp_hi    <= 32'd0;
         temp_lo    <= 32'd0;
         skip_write <= 1'b0;
         E_HI       <= 32'd0;
         E_LO       <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= BUSY;
                  busy       <= 1'b1;
                  temp_hi    <= res_hi;
                  temp_lo    <= res_lo;
                  cnt        <= is_mult ? 32'(MULT_CYCLES) : 32'(DIV_CYCLES);
                  skip_write <= is_div && div_zero;
               end else if (!Req && E_MDU_Ctr == OP_MTHI) begin
                  E_HI <= E_A;
               end else if (!Req && E_MDU_Ctr == OP_MTLO) begin
                  E_LO <= E_A;
               end
            end
            BUSY: begin
               // Flush and late mthi/mtlo are ignored here; the op always finishes.
               cnt <= cnt - 32'd1;
               if (cnt == 32'd1) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  if (!skip_write) begin
                     E_HI <= temp_hi;
                     E_LO <= temp_lo;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multiply/divide sequencer for the pipelined MIPS core.
- Owns the HI/LO registers and launches multi-cycle mult/multu/div/divu from E-stage.
- Counts operation latency, drives busy/start, and generates the D-stage stall for MDU-class instructions.
- Feeds HI/LO to E-stage result selection for mfhi/mflo. Suppresses launches and writes when a flush request (exception/interrupt) is raised.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (legal range ≥1)
DIV_CYCLES, 10, busy cycles for div/divu (legal range ≥1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
E_MDU_Ctr  input  4  E-stage MDU op: 0000 none, 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mfhi, 0110 mflo, 0111 mthi, 1000 mtlo
E_A  input  32  rs operand (forwarded)
E_B  input  32  rt operand (forwarded)
Req  input  1  flush request; E-stage instruction is cancelled this cycle
D_MDU_Use  input  1  D-stage instruction is any MDU op (0001–1000)
E_HI  output  32  HI register
E_LO  output  32  LO register
start  output  1  combinational; launch this cycle
busy  output  1  registered; operation in flight
D_Stall_MDU  output  1  combinational stall to D/F

Behaviour:
- Reset (reset=0, async): E_HI=0, E_LO=0, busy=0, state IDLE, cnt=0, temp_hi/temp_lo=0. Reset mid-operation aborts it; HI/LO are not written.
- start = (E_MDU_Ctr ∈ {0001..0100}) & ~Req & (state==IDLE).
- D_Stall_MDU = D_MDU_Use & (start | busy).
- States: IDLE, BUSY.
  - IDLE→BUSY on start.
  - On the launch edge:
    - temp_{hi,lo} ← result computed from E_A/E_B.
    - cnt ← MULT_CYCLES for mult/multu, DIV_CYCLES for div/divu.
    - busy←1.
  - BUSY: cnt decrements each edge.
  - When cnt==1 at an edge: E_HI←temp_hi, E_LO←temp_lo, busy←0, state IDLE.
- Latency: start in cycle t ⇒ busy=1 in cycles t+1..t+N. New HI/LO visible from cycle t+N+1, the same cycle busy reads 0.
- Arithmetic:
  - mult: 64-bit signed product, HI=[63:32], LO=[31:0].
  - multu: unsigned product, same split.
  - div: LO=signed quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - Divisor 0: operation still runs full DIV_CYCLES, but HI/LO stay unchanged at completion.
  - 0x80000000 / -1 (div): LO=0x80000000, HI=0.
- mthi/mtlo: in IDLE with ~Req, E_HI (or E_LO) ← E_A at the edge and are visible the next cycle. Stall guarantees these never reach E while busy. If they do arrive while busy, they are ignored.
- mfhi/mflo: no state change here; E_HI/E_LO read combinationally by the selector.
- Req:
  - Blocks start and mthi/mtlo in the same cycle.
  - Does not cancel an operation already in BUSY; it completes and writes HI/LO.
- Launch request while BUSY is impossible (stall) and is ignored.
- Idle with E_MDU_Ctr=0000: all state holds.

Test Plan:
- Reset low for 2 cycles, release; E_A=0xFFFFFFFF, E_B=2, mult at t → start=1 in t; busy=1 in t+1..t+5; in t+6 E_HI=0xFFFFFFFF, E_LO=0xFFFFFFFE, busy=0.
- Same operands, multu → HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles. Then div E_A=0xFFFFFFF9 (−7), E_B=2 → 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu E_A=7, E_B=2 → LO=3, HI=1.
- Stall: launch div; hold D_MDU_Use=1 (mflo in D) → D_Stall_MDU=1 in start cycle and all 10 busy cycles, 0 in the cycle HI/LO update. D_MDU_Use=0 → stall stays 0 throughout.
- Flush:
  - mult with Req=1 → start=0, busy stays 0, HI/LO unchanged.
  - mthi E_A=0x1234 with Req=1 → HI unchanged. Repeat with Req=0 → HI=0x1234 next cycle.
  - Req=1 during BUSY → operation still completes and writes.
- Divide by zero: HI=0xAAAA, LO=0x5555 preset via mthi/mtlo; div E_B=0 → busy 10 cycles, HI/LO remain 0xAAAA/0x5555. Overflow div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Reset mid-op: launch mult, assert reset=0 asynchronously in busy cycle 3 → busy, E_HI, E_LO drop to 0 immediately without waiting for a clock edge. After release, state IDLE and no late HI/LO write.
